// File: rtl/rgu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgu_pkg : shared types and register map for the staged reset unit     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rgu_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic [2:0] {
        ST_HOLD0 = 3'd0,
        ST_HOLD1 = 3'd1,
        ST_HOLD2 = 3'd2,
        ST_HOLD3 = 3'd3,
        ST_DONE  = 3'd4
    } rgu_state_e;

    localparam logic [11:0] OFF_CTRL       = 12'h000;
    localparam logic [11:0] OFF_STATUS     = 12'h004;
    localparam logic [11:0] OFF_TIMER_BASE = 12'h008;
    localparam logic [11:0] OFF_SWRST      = 12'h020;
    localparam logic [11:0] OFF_STATE      = 12'h024;

    localparam int STS_POR      = 0;
    localparam int STS_EXT      = 1;
    localparam int STS_GSW      = 2;
    localparam int STS_WDT_BASE = 8;

endpackage
`default_nettype wire

// File: rtl/rgu_sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgu_sync_debounce : 2-flop synchroniser plus low-run qualifier        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rgu_sync_debounce #(
    parameter int DEPTH = 1
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic async_rst_n,
    output logic trig
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] run_d;
    logic [CW-1:0] run_q;

    // run_q saturates at DEPTH-1, so trig fires on the DEPTH-th low cycle and stays up while low
    always_comb begin
        run_d = run_q;
        if (sync_q) begin
            run_d = '0;
        end else if (run_q != CW'(DEPTH - 1)) begin
            run_d = run_q + 1'b1;
        end
        trig = ~sync_q & (run_q == CW'(DEPTH - 1));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            run_q  <= '0;
        end else begin
            meta_q <= async_rst_n;
            sync_q <= meta_q;
            run_q  <= run_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgu_staged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgu_staged : staged reset sequencer with APB timers and cause log     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rgu_staged
    import rgu_pkg::*;
#(
    parameter int                   NUM_RST    = 32,
    parameter int                   NUM_STAGES = 2,
    parameter int                   NUM_WDT    = 4,
    parameter int                   TIMER_W    = 16,
    parameter int                   TIMER_RST  = 16,
    parameter int                   DEBOUNCE   = 4,
    parameter logic [2*NUM_RST-1:0] STAGE_MAP  = '0
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               ext_rst_n,
    input  logic [NUM_WDT-1:0] wdt_rst_n,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [11:0]        PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic [NUM_RST-1:0] rst_n,
    output logic               rst_done
);

    logic               ext_trig;
    logic [NUM_WDT-1:0] wdt_trig;

    rgu_sync_debounce #(.DEPTH(DEBOUNCE)) u_ext_sync (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .async_rst_n (ext_rst_n),
        .trig        (ext_trig)
    );

    for (genvar j = 0; j < NUM_WDT; j++) begin : g_wdt_sync
        rgu_sync_debounce #(.DEPTH(1)) u_wdt_sync (
            .PCLK        (PCLK),
            .PRESETn     (PRESETn),
            .async_rst_n (wdt_rst_n[j]),
            .trig        (wdt_trig[j])
        );
    end

    rgu_state_e              state_d, state_q;
    logic [TIMER_W-1:0]      cnt_d, cnt_q;
    logic [MAX_STAGES-1:0]   released_d, released_q;
    logic [TIMER_W-1:0]      timer_d [MAX_STAGES];
    logic [TIMER_W-1:0]      timer_q [MAX_STAGES];
    logic [31:0]             status_d, status_q;
    logic [NUM_RST-1:0]      swrst_d, swrst_q;
    logic                    gsw_d, gsw_q;
    logic [NUM_RST-1:0]      rst_n_d, rst_n_q;
    logic                    rst_done_d, rst_done_q;
    logic [31:0]             prdata_d, prdata_q;
    logic                    pslverr_d, pslverr_q;

    logic        setup, wr_en, addr_err, timer_hit, trigger;
    logic [2:0]  timer_idx;
    logic [1:0]  stage, stage_rd;
    logic [31:0] rd_val, status_set;

    always_comb begin
        setup     = PSEL & ~PENABLE;
        timer_hit = (PADDR[11:5] == 7'd0) && (PADDR[1:0] == 2'd0) && (PADDR[4:3] != 2'd0);
        timer_idx = PADDR[4:2] - 3'd2;
        case (PADDR)
            OFF_CTRL, OFF_STATUS, OFF_SWRST: addr_err = 1'b0;
            OFF_STATE:                       addr_err = PWRITE;
            default:                         addr_err = !(timer_hit && (int'(timer_idx) < NUM_STAGES));
        endcase
        wr_en = PSEL & PENABLE & PWRITE & ~addr_err;

        stage    = state_q[1:0];
        stage_rd = (state_q == ST_DONE) ? 2'(NUM_STAGES - 1) : stage;

        rd_val = '0;
        case (PADDR)
            OFF_STATUS: rd_val = status_q;
            OFF_SWRST:  rd_val[NUM_RST-1:0] = swrst_q;
            OFF_STATE:  rd_val[2:0] = {rst_done_q, stage_rd};
            default:    if (timer_hit) rd_val[TIMER_W-1:0] = timer_q[timer_idx[1:0]];
        endcase

        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (setup) begin
            pslverr_d = addr_err;
            if (!PWRITE && !addr_err) prdata_d = rd_val;
        end

        gsw_d   = wr_en && (PADDR == OFF_CTRL) && PWDATA[0];
        trigger = ext_trig | (|wdt_trig) | gsw_q;

        for (int k = 0; k < MAX_STAGES; k++) begin
            timer_d[k] = timer_q[k];
            if (k < NUM_STAGES && wr_en && timer_hit && timer_idx == 3'(k)) begin
                timer_d[k] = PWDATA[TIMER_W-1:0];
            end
        end

        status_set                              = '0;
        status_set[STS_EXT]                     = ext_trig;
        status_set[STS_GSW]                     = gsw_q;
        status_set[STS_WDT_BASE +: NUM_WDT]     = wdt_trig;
        status_d = status_q;
        if (wr_en && PADDR == OFF_STATUS) status_d = status_q & ~PWDATA;
        status_d = status_d | status_set;

        swrst_d = swrst_q;
        if (wr_en && PADDR == OFF_SWRST) swrst_d = PWDATA[NUM_RST-1:0];
        if (trigger) swrst_d = '0;

        state_d    = state_q;
        cnt_d      = cnt_q;
        released_d = released_q;
        if (trigger) begin
            state_d    = ST_HOLD0;
            cnt_d      = timer_q[0];
            released_d = '0;
        end else if (state_q != ST_DONE) begin
            if (cnt_q == '0) begin
                released_d[stage] = 1'b1;
                if (int'(stage) == NUM_STAGES - 1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = rgu_state_e'(state_q + 3'd1);
                    cnt_d   = timer_q[stage + 2'd1];
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // A watchdog bite pulls rst_n directly, one edge ahead of the stage flops
        for (int i = 0; i < NUM_RST; i++) begin
            rst_n_d[i] = released_q[STAGE_MAP[2*i +: 2]] & ~swrst_q[i] & ~(|wdt_trig);
        end
        rst_done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_HOLD0;
            cnt_q      <= TIMER_W'(TIMER_RST);
            released_q <= '0;
            for (int k = 0; k < MAX_STAGES; k++) timer_q[k] <= TIMER_W'(TIMER_RST);
            status_q   <= 32'h1 << STS_POR;
            swrst_q    <= '0;
            gsw_q      <= 1'b0;
            rst_n_q    <= '0;
            rst_done_q <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            released_q <= released_d;
            for (int k = 0; k < MAX_STAGES; k++) timer_q[k] <= timer_d[k];
            status_q   <= status_d;
            swrst_q    <= swrst_d;
            gsw_q      <= gsw_d;
            rst_n_q    <= rst_n_d;
            rst_done_q <= rst_done_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PSLVERR  = pslverr_q;
    assign PREADY   = 1'b1;
    assign rst_n    = rst_n_q;
    assign rst_done = rst_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgu_staged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rgu_staged : directed self-checking bench for rgu_staged           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rgu_staged;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        ext_rst_n = 1'b1;
    logic [3:0]  wdt_rst_n = 4'hF;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] rst_n;
    logic        rst_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    rgu_staged #(
        .NUM_RST    (32),
        .NUM_STAGES (2),
        .NUM_WDT    (4),
        .TIMER_W    (16),
        .TIMER_RST  (16),
        .DEBOUNCE   (4),
        .STAGE_MAP  (64'h5555_5555_5555_0000)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .ext_rst_n (ext_rst_n),
        .wdt_rst_n (wdt_rst_n),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .rst_n     (rst_n),
        .rst_done  (rst_done)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        tick();
        PENABLE = 1'b1;
        d   = PRDATA;
        err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL reset_rst_n: got %h want %h", rst_n, 32'h0); end
        n_vec++; if (rst_done !== 1'b0) begin n_err++; $display("FAIL reset_rst_done: got %b want 0", rst_done); end
        n_vec++; if (PRDATA !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
        n_vec++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
        n_vec++; if (PREADY !== 1'b1) begin n_err++; $display("FAIL reset_pready: got %b want 1", PREADY); end
    endtask

    task automatic test_power_on();
        logic [31:0] d;
        logic        e;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 17) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL por_c17: got %h want %h", rst_n, 32'h0); end
            end
            if (c == 18) begin
                n_vec++; if (rst_n !== 32'h0000_00FF) begin n_err++; $display("FAIL por_c18: got %h want %h", rst_n, 32'hFF); end
            end
            if (c == 34) begin
                n_vec++; if (rst_n !== 32'h0000_00FF || rst_done !== 1'b0) begin
                    n_err++; $display("FAIL por_c34: got %h/%b want %h/0", rst_n, rst_done, 32'hFF);
                end
            end
            if (c == 35) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF || rst_done !== 1'b1) begin
                    n_err++; $display("FAIL por_c35: got %h/%b want ffffffff/1", rst_n, rst_done);
                end
            end
        end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h1 || e !== 1'b0) begin n_err++; $display("FAIL por_status: got %h err %b want 1 err 0", d, e); end
        apb_read(12'h024, d, e);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL por_state: got %h want 5", d); end
        apb_read(12'h008, d, e);
        n_vec++; if (d !== 32'h10) begin n_err++; $display("FAIL por_timer0: got %h want 10", d); end
    endtask

    task automatic test_gswrst();
        logic [31:0] d;
        logic        e;
        apb_write(12'h008, 32'd3, e);
        apb_write(12'h00C, 32'd0, e);
        apb_write(12'h000, 32'd1, e);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL gsw_c1: got %h want ffffffff", rst_n); end
            end
            if (c == 2) begin
                n_vec++; if (rst_n !== 32'h0 || rst_done !== 1'b0) begin n_err++; $display("FAIL gsw_c2: got %h/%b want 0/0", rst_n, rst_done); end
            end
            if (c == 5) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL gsw_c5: got %h want 0", rst_n); end
            end
            if (c == 6) begin
                n_vec++; if (rst_n !== 32'h0000_00FF) begin n_err++; $display("FAIL gsw_c6: got %h want ff", rst_n); end
            end
            if (c == 7) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF || rst_done !== 1'b1) begin
                    n_err++; $display("FAIL gsw_c7: got %h/%b want ffffffff/1", rst_n, rst_done);
                end
            end
        end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL gsw_status: got %h want 5", d); end
        apb_write(12'h004, 32'h5, e);
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL gsw_w1c: got %h want 0", d); end
        apb_read(12'h000, d, e);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_read: got %h want 0", d); end
    endtask

    task automatic test_ext_debounce();
        logic [31:0] d;
        logic        e;
        logic        bad;
        bad = 1'b0;
        ext_rst_n = 1'b0;
        tick(); tick(); tick();
        ext_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rst_n !== 32'hFFFF_FFFF) bad = 1'b1;
        end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL ext_glitch: rst_n dipped, got bad=%b want 0", bad); end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ext_glitch_status: got %h want 0", d); end
        ext_rst_n = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 6) begin
                ext_rst_n = 1'b1;
                n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_c6: got %h want ffffffff", rst_n); end
            end
            if (c == 7) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL ext_c7: got %h want 0", rst_n); end
            end
            if (c == 12) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL ext_c12: got %h want 0", rst_n); end
            end
            if (c == 13) begin
                n_vec++; if (rst_n !== 32'h0000_00FF) begin n_err++; $display("FAIL ext_c13: got %h want ff", rst_n); end
            end
            if (c == 14) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_c14: got %h want ffffffff", rst_n); end
            end
        end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ext_status: got %h want 2", d); end
    endtask

    task automatic test_wdt();
        logic [31:0] d;
        logic        e;
        wdt_rst_n = 4'b1011;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) wdt_rst_n = 4'hF;
            if (c == 2) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wdt_c2: got %h want ffffffff", rst_n); end
            end
            if (c == 3) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL wdt_c3: got %h want 0", rst_n); end
            end
            if (c == 7) begin
                n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL wdt_c7: got %h want 0", rst_n); end
            end
            if (c == 8) begin
                n_vec++; if (rst_n !== 32'h0000_00FF) begin n_err++; $display("FAIL wdt_c8: got %h want ff", rst_n); end
            end
            if (c == 9) begin
                n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wdt_c9: got %h want ffffffff", rst_n); end
            end
        end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h402) begin n_err++; $display("FAIL wdt_status: got %h want 402", d); end
        apb_write(12'h004, 32'hFFFF_FFFF, e);
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL wdt_w1c: got %h want 0", d); end
    endtask

    task automatic test_wdt_vs_swrst();
        logic [31:0] d;
        logic        e;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h020; PWDATA = 32'hFF;
        tick();
        PENABLE = 1'b1;
        wdt_rst_n = 4'b1011;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        wdt_rst_n = 4'hF;
        tick();
        n_vec++; if (rst_n !== 32'hFFFF_FF00) begin n_err++; $display("FAIL wsw_c2: got %h want ffffff00", rst_n); end
        tick();
        n_vec++; if (rst_n !== 32'h0) begin n_err++; $display("FAIL wsw_c3: got %h want 0", rst_n); end
        for (int c = 0; c < 10; c++) tick();
        apb_read(12'h020, d, e);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL wsw_swrst: got %h want 0", d); end
        n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wsw_rst_n: got %h want ffffffff", rst_n); end
        apb_read(12'h004, d, e);
        n_vec++; if (d !== 32'h400) begin n_err++; $display("FAIL wsw_status: got %h want 400", d); end
    endtask

    task automatic test_swrst();
        logic [31:0] d;
        logic        e;
        apb_write(12'h020, 32'h4, e);
        n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL swrst_c0: got %h want ffffffff", rst_n); end
        tick();
        n_vec++; if (rst_n !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL swrst_c1: got %h want fffffffb", rst_n); end
        apb_read(12'h020, d, e);
        n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL swrst_read: got %h want 4", d); end
        apb_write(12'h020, 32'h0, e);
        tick();
        n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL swrst_clear: got %h want ffffffff", rst_n); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        apb_read(12'h030, d, e);
        n_vec++; if (e !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL err_rd030: got %h err %b want 0 err 1", d, e); end
        n_vec++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL err_release: got %b want 0", PSLVERR); end
        apb_write(12'h024, 32'hFFFF_FFFF, e);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wr024: got %b want 1", e); end
        apb_read(12'h024, d, e);
        n_vec++; if (e !== 1'b0 || d !== 32'h5) begin n_err++; $display("FAIL err_state: got %h err %b want 5 err 0", d, e); end
        apb_read(12'h010, d, e);
        n_vec++; if (e !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL err_rd_timer2: got %h err %b want 0 err 1", d, e); end
        apb_write(12'h010, 32'h7, e);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_wr_timer2: got %b want 1", e); end
        apb_read(12'h008, d, e);
        n_vec++; if (e !== 1'b0 || d !== 32'h3) begin n_err++; $display("FAIL err_timer0: got %h err %b want 3 err 0", d, e); end
        apb_read(12'h006, d, e);
        n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_unaligned: got %b want 1", e); end
        n_vec++; if (rst_n !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL err_rst_n: got %h want ffffffff", rst_n); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_gswrst();
        test_ext_debounce();
        test_wdt();
        test_wdt_vs_swrst();
        test_swrst();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, limit 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rgu_staged.md
# rgu_staged

Parametrised reset generation unit: sequences up to NUM_STAGES reset-release stages with APB-programmable hold timers, drives NUM_RST reset outputs, each mapped to a stage and maskable by a per-output software reset bit. It sits between the power/board reset sources and every IP domain and records the cause of the last reset. It generalises the fixed two-stage RGU with configurable channel count, stage count, stage mapping and watchdog inputs. It also adds debounced external reset, a global software reset and W1C cause logging.

## Interface
- NUM_RST, 32: reset outputs, 1..32
- NUM_STAGES, 2: release stages, 1..4
- NUM_WDT, 4: watchdog reset inputs, 1..8
- TIMER_W, 16: stage timer width
- TIMER_RST, 16: reset value of every stage timer
- DEBOUNCE, 4: consecutive low cycles needed on ext_rst_n, ≥1
- STAGE_MAP, 0: packed [2*NUM_RST-1:0]; bits [2i+1:2i] give the stage of output i, and must be < NUM_STAGES
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low (power-good)
- ext_rst_n  in  1  asynchronous board reset, active-low
- wdt_rst_n  in  NUM_WDT  asynchronous watchdog resets, active-low
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  12  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  always 1 out of reset
- PSLVERR  out  1  access error
- rst_n  out  NUM_RST  per-domain reset, active-low, registered
- rst_done  out  1  all stages released

## Operation
- Registers:
  - 0x000 CTRL, bit0 GSWRST: write 1 to trigger a global reset sequence. Self-clearing; reads 0.
  - 0x004 STATUS, W1C, sticky cause bits: bit0 power-on, bit1 external, bit2 global software, bits[8+j] wdt j.
  - 0x008+4k TIMERk (k<NUM_STAGES), TIMER_W bits: hold cycles before stage k is released.
  - 0x020 SWRST, bit i holds rst_n[i] low.
  - 0x024 STATE, read-only, returns {rst_done, stage index}.
- Unmapped offsets, TIMERk with k≥NUM_STAGES, and writes to 0x024 set PSLVERR for that access and have no effect.
- Input conditioning: ext_rst_n and each wdt_rst_n pass through a 2-flop synchroniser. ext_rst_n is then debounced and triggers only after DEBOUNCE consecutive synchronised-low cycles. wdt triggers on any synchronised-low cycle.
- Trigger = debounced ext low | any wdt low | GSWRST write.
- FSM states: HOLD(k) for k=0..NUM_STAGES-1, then DONE.
  - Reset state is HOLD(0) with the counter loaded from TIMER0.
  - In HOLD(k) the counter decrements. At 0, stage k is marked released and the FSM moves to HOLD(k+1) with a load from TIMERk+1, or to DONE after the last stage.
  - Trigger in any state: go to HOLD(0), clear all released flags, reload the counter, clear SWRST, and set the STATUS cause bit(s).
  - Trigger held (level) keeps the FSM in HOLD(0) with the counter reloaded.
- rst_n[i] <= released[STAGE_MAP[i]] & ~SWRST[i].
- rst_done <= (state==DONE).

## Timing
- PRESETn low: rst_n=0, rst_done=0, PRDATA=0, PSLVERR=0, PREADY=1, STATUS=0x1, TIMERk=TIMER_RST, SWRST=0, FSM in HOLD(0). The debounce counter clears and synchroniser flops reset to 1.
- APB:
  - Zero wait states. Writes commit on the access phase (PSEL&PENABLE&PWRITE).
  - PRDATA and PSLVERR are registered during the setup phase and are valid throughout the access phase. PSLVERR is 0 outside an erroring access.
- Stage timing:
  - After PRESETn rises, stage k is released TIMER0+…+TIMERk+(k+1) cycles later.
  - rst_n follows the release one cycle after that (registered).
  - A timer value of 0 releases the stage on the next cycle.
- Trigger latency:
  - wdt: rst_n goes low 3 PCLK edges after wdt_rst_n falls (2 sync + 1 output register).
  - ext: 2+DEBOUNCE+1 edges after ext_rst_n falls.
  - GSWRST: 2 edges after the access-phase edge.
- TIMER write during a count: takes effect at the next load; the running count is not altered.
- Simultaneous events:
  - Trigger wins over a same-cycle SWRST write; SWRST ends up 0.
  - A cause set wins over a same-cycle W1C of the same bit.
  - Multiple simultaneous causes all set.
- An ext_rst_n glitch shorter than DEBOUNCE synchronised cycles is ignored.

## Structure
- Package rgu_pkg holds:
  - the FSM state typedef
  - register offset localparams (CTRL, STATUS, TIMER_BASE, SWRST, STATE)
  - STATUS bit-position constants
- Sub-module rgu_sync_debounce (param DEPTH) contains the 2-flop synchroniser plus the low-run counter. It is instantiated once for ext with DEPTH=DEBOUNCE and per wdt with DEPTH=1.

## Test plan
- Power-on with NUM_STAGES=2, TIMER_RST=16, STAGE_MAP with outputs 0–7 in stage 0 and the rest in stage 1, PRESETn released: rst_n[7:0] rises at cycle 18 and rst_n[31:8] at cycle 35. rst_done=1 at 35. STATUS=0x1.
- Write TIMER0=3, TIMER1=0, then CTRL=1: all rst_n go low 2 cycles later. Stage 0 then releases 5 cycles after that and stage 1 one cycle later. STATUS reads 0x5; writing STATUS=0x5 makes it read 0x0.
- ext_rst_n low for 3 cycles (DEBOUNCE=4): no reset and STATUS unchanged. Held low for 6 cycles: reset sequence runs and STATUS bit1 is set.
- wdt_rst_n[2] pulsed low for 1 cycle in DONE: rst_n goes 0 three edges later and STATUS bit10 is set. The same pulse in the same cycle as a SWRST=0xFF write leaves SWRST at 0.
- SWRST=0x00000004 in DONE: only rst_n[2] goes low one cycle after the write. Writing 0 restores it.
- Read 0x030 and write 0x024: PSLVERR=1 for that access only, no register change, PRDATA=0.
